// File: rtl/kick_cfg_pkg.sv
// Shared configuration for the Kickstart relocator family: E-clock hold timing,
// slot encoding helper and the autoconfig identity constants.
package kick_cfg_pkg;

  // Hold/step timing for the 709 kHz E clock (~1.5 s first hold, ~0.75 s per step).
  localparam int HOLD_CYCLES_DEF = 2 ** 20;
  localparam int STEP_CYCLES_DEF = 2 ** 19;

  localparam logic [15:0] AC_MANUF_ID  = 16'h0A1C;
  localparam logic [7:0]  AC_PRODUCT   = 8'h4B;
  localparam logic [31:0] AC_SERIAL    = 32'h4B53_0001;

  // The motherboard ROM sits one past the last flash bank.
  function automatic int mbSlot(input int numBanks);
    return numBanks;
  endfunction

endpackage

// File: rtl/kick_slot_next.sv
// Combinational finder for the next valid Kickstart slot after sel, wrapping
// through the flash banks and the motherboard ROM.
module kick_slot_next
  import kick_cfg_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int SLOT_W    = $clog2(NUM_BANKS + 1)
) (
  input  logic [SLOT_W-1:0]    sel,
  input  logic [NUM_BANKS-1:0] bankMask,
  input  logic                 size1M,
  output logic [SLOT_W-1:0]    nextSel
);

  localparam logic [SLOT_W-1:0] MB_SLOT = SLOT_W'(mbSlot(NUM_BANKS));

  logic [NUM_BANKS:0] slotPresent;
  logic [SLOT_W-1:0]  cand;
  logic               found;
  logic               candValid;

  assign slotPresent = {1'b1, bankMask};

  // The motherboard slot is always present, so the scan always lands somewhere.
  always_comb begin
    nextSel   = MB_SLOT;
    found     = 1'b0;
    cand      = '0;
    candValid = 1'b0;
    for (int k = 1; k <= NUM_BANKS + 1; k++) begin
      cand      = SLOT_W'((int'(sel) + k) % (NUM_BANKS + 1));
      candValid = slotPresent[cand] && ((cand == MB_SLOT) || !size1M || !cand[0]);
      if (!found && candValid) begin
        nextSel = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kick_bank_selector.sv
// Keyboard-reset hold timer that steps a persistent Kickstart slot selection
// through the populated flash banks and the motherboard ROM.
module kick_bank_selector
  import kick_cfg_pkg::*;
#(
  parameter int                   NUM_BANKS    = 4,
  parameter logic [NUM_BANKS-1:0] BANK_MASK    = '1,
  parameter int                   DEFAULT_SLOT = 0,
  parameter int                   HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int                   STEP_CYCLES  = STEP_CYCLES_DEF,
  localparam int                  SLOT_W       = $clog2(NUM_BANKS + 1)
) (
  input  logic              E_CLK,
  input  logic              RESET_n,
  input  logic              SIZE_1M,
  output logic [SLOT_W-2:0] BANK_SEL,
  output logic              USE_MB,
  output logic              STEP_PULSE,
  output logic              HOLDING
);

  localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  HOLD_T  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STEP_T  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [SLOT_W-1:0] MB_SLOT = SLOT_W'(mbSlot(NUM_BANKS));

  logic [CNT_W-1:0]  cnt;
  logic              first;
  logic              pulse;
  logic              atThresh;
  logic [SLOT_W-1:0] nextSel;
  logic [SLOT_W-2:0] bankLow;

  // Selection survives every reset; only configuration loads the default.
  logic [SLOT_W-1:0] sel = SLOT_W'(DEFAULT_SLOT);

  assign atThresh = (cnt == (first ? HOLD_T : STEP_T));

  always_ff @(posedge E_CLK or posedge RESET_n) begin
    if (RESET_n) begin
      cnt   <= '0;
      first <= 1'b1;
      pulse <= 1'b0;
    end else if (atThresh) begin
      cnt   <= '0;
      first <= 1'b0;
      pulse <= 1'b1;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      pulse <= 1'b0;
    end
  end

  // Gating on RESET_n keeps a release that races the threshold edge from committing.
  always_ff @(posedge E_CLK) begin
    if (!RESET_n && atThresh) begin
      sel <= nextSel;
    end
  end

  kick_slot_next #(
    .NUM_BANKS(NUM_BANKS),
    .SLOT_W   (SLOT_W)
  ) uSlotNext (
    .sel     (sel),
    .bankMask(BANK_MASK),
    .size1M  (SIZE_1M),
    .nextSel (nextSel)
  );

  always_comb begin
    bankLow = sel[SLOT_W-2:0];
    if (SIZE_1M) begin
      bankLow[0] = 1'b0;
    end
  end

  assign USE_MB     = (sel == MB_SLOT);
  assign BANK_SEL   = USE_MB ? '0 : bankLow;
  assign HOLDING    = !first;
  assign STEP_PULSE = pulse;

endmodule

// File: tb/tb_kick_bank_selector.sv
// Directed bench for kick_bank_selector with short hold/step timing on two
// instances: all banks populated, and banks 0, 1, 3 populated.
module tb_kick_bank_selector;

  logic       clk = 1'b0;
  logic       rstA = 1'b0;
  logic       sizeA = 1'b0;
  logic       rstB = 1'b0;
  logic       sizeB = 1'b0;
  logic [1:0] bankA, bankB;
  logic       mbA, mbB, pulseA, pulseB, holdA, holdB;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  kick_bank_selector #(
    .NUM_BANKS(4), .BANK_MASK(4'b1111), .DEFAULT_SLOT(0),
    .HOLD_CYCLES(8), .STEP_CYCLES(4)
  ) dutA (
    .E_CLK(clk), .RESET_n(rstA), .SIZE_1M(sizeA),
    .BANK_SEL(bankA), .USE_MB(mbA), .STEP_PULSE(pulseA), .HOLDING(holdA)
  );

  kick_bank_selector #(
    .NUM_BANKS(4), .BANK_MASK(4'b1011), .DEFAULT_SLOT(0),
    .HOLD_CYCLES(8), .STEP_CYCLES(4)
  ) dutB (
    .E_CLK(clk), .RESET_n(rstB), .SIZE_1M(sizeB),
    .BANK_SEL(bankB), .USE_MB(mbB), .STEP_PULSE(pulseB), .HOLDING(holdB)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chkA(input string tag, input int bank, input int mb, input int pls, input int hld);
    chk({tag, ".bank"}, int'(bankA), bank);
    chk({tag, ".mb"}, int'(mbA), mb);
    chk({tag, ".pulse"}, int'(pulseA), pls);
    chk({tag, ".hold"}, int'(holdA), hld);
  endtask

  task automatic chkB(input string tag, input int bank, input int mb, input int pls, input int hld);
    chk({tag, ".bank"}, int'(bankB), bank);
    chk({tag, ".mb"}, int'(mbB), mb);
    chk({tag, ".pulse"}, int'(pulseB), pls);
    chk({tag, ".hold"}, int'(holdB), hld);
  endtask

  initial begin
    #1;
    rstA = 1'b1;
    rstB = 1'b1;
    step(2);
    chkA("rstA", 0, 0, 0, 0);
    chkB("rstB", 0, 0, 0, 0);

    // Short reset: 7 edges never reaches the hold threshold.
    rstA = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chkA($sformatf("short%0d", i), 0, 0, 0, 0);
    end
    rstA = 1'b1;
    step(2);
    chkA("shortRel", 0, 0, 0, 0);

    // Single advance on edge 8, then release and a short reboot.
    rstA = 1'b0;
    step(7);
    chkA("single7", 0, 0, 0, 0);
    step(1);
    chkA("single8", 1, 0, 1, 1);
    step(1);
    chkA("single9", 1, 0, 0, 1);
    rstA = 1'b1;
    #1;
    chkA("singleRel", 1, 0, 0, 0);
    step(1);
    rstA = 1'b0;
    step(3);
    rstA = 1'b1;
    step(1);
    chkA("reboot", 1, 0, 0, 0);

    // Reset mid-operation: next advance after re-hold must take the full 8 edges.
    rstA = 1'b0;
    step(11);
    chkA("mid11", 2, 0, 0, 1);
    rstA = 1'b1;
    step(1);
    chkA("midRel", 2, 0, 0, 0);
    rstA = 1'b0;
    step(7);
    chkA("midRe7", 2, 0, 0, 0);
    step(1);
    chkA("midRe8", 3, 0, 1, 1);
    rstA = 1'b1;
    step(1);

    // Walk sel 3 -> 4 -> 0 -> 1 so the 1 MB case starts from an odd slot.
    rstA = 1'b0;
    step(8);
    chkA("walkMb", 0, 1, 1, 1);
    step(4);
    chkA("walk0", 0, 0, 1, 1);
    step(4);
    chkA("walk1", 1, 0, 1, 1);
    rstA = 1'b1;
    step(1);
    sizeA = 1'b1;
    #1;
    chkA("size1Mask", 0, 0, 0, 0);
    step(1);
    rstA = 1'b0;
    step(8);
    chkA("size1Adv2", 2, 0, 1, 1);
    step(4);
    chkA("size1AdvMb", 0, 1, 1, 1);
    step(4);
    chkA("size1Wrap", 0, 0, 1, 1);
    rstA = 1'b1;
    step(1);

    // Sparse mask 1011: 0 -> 1 -> 3 -> MB -> 0 under a continuous hold.
    rstB = 1'b0;
    step(7);
    chkB("maskE7", 0, 0, 0, 0);
    step(1);
    chkB("maskE8", 1, 0, 1, 1);
    step(3);
    chkB("maskE11", 1, 0, 0, 1);
    step(1);
    chkB("maskE12", 3, 0, 1, 1);
    step(4);
    chkB("maskE16", 0, 1, 1, 1);
    step(4);
    chkB("maskE20", 0, 0, 1, 1);
    rstB = 1'b1;
    step(1);
    chkB("maskRel", 0, 0, 0, 0);

    // Release 1 ns before the threshold edge: no advance.
    rstB = 1'b0;
    step(7);
    #4;
    rstB = 1'b1;
    @(negedge clk);
    chkB("bound", 0, 0, 0, 0);
    step(2);
    chkB("boundLate", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
